// File: rtl/sha2_pkg.sv
// Shared constants, schedule FSM state type and the SHA-256 small sigma
// functions used by the message schedule.
package sha2_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  function automatic logic [WORD_SIZE-1:0] small_sigma0(input logic [WORD_SIZE-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_SIZE-1:0] small_sigma1(input logic [WORD_SIZE-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_window.sv
// 16-word sliding window for the SHA-256 message schedule: parallel load of a
// block, shift with sigma feedback into the top slot, or freeze.
module sha256_sched_window
  import sha2_pkg::*;
(
  input  logic                             clock,
  input  logic                             clear,
  input  logic                             load,
  input  logic                             shift,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] block_in,
  output logic [WORD_SIZE-1:0]             w0
);

  logic [WORD_SIZE-1:0] w_q [BLOCK_WORDS];
  logic [WORD_SIZE-1:0] w_d [BLOCK_WORDS];
  logic [WORD_SIZE-1:0] feedback;

  // W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t, relative to the window base
  assign feedback = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      w_d[i] = w_q[i];
    end
    if (load) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        w_d[i] = block_in[(BLOCK_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
      end
    end else if (shift) begin
      for (int i = 0; i < BLOCK_WORDS-1; i++) begin
        w_d[i] = w_q[i+1];
      end
      w_d[BLOCK_WORDS-1] = feedback;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign w0 = w_q[0];

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: accepts a 512-bit block and emits W0..W63, one per
// unheld cycle. Optional round_index output enabled by SHA256_SCHED_ROUND_IDX_EN.
//
// state | meaning
// IDLE  | waiting for a block, block_ready high unless clear
// RUN   | emitting W_t from the window, t counts 0..63, hold freezes
module sha256_message_schedule
  import sha2_pkg::*;
(
  input  logic                             clock,
  input  logic                             clear,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] block_in,
  input  logic                             block_valid,
  output logic                             block_ready,
  input  logic                             hold,
  output logic [WORD_SIZE-1:0]             message_schedule_value,
  output logic                             round_valid,
  output logic                             first_round,
  output logic                             last_round,
  output logic                             busy
`ifdef SHA256_SCHED_ROUND_IDX_EN
  ,
  output logic [5:0]                       round_index
`endif
);

  sched_state_e state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic         accept;
  logic         step;

  assign accept = (state_q == IDLE) && block_valid && !clear;
  assign step   = (state_q == RUN) && !hold;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (step) begin
          t_d = t_q + 6'd1;
          if (t_q == LAST_T) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    block_ready = (state_q == IDLE) && !clear;
    busy        = (state_q == RUN);
    round_valid = step;
    first_round = step && (t_q == 6'd0);
    last_round  = step && (t_q == LAST_T);
  end

  sha256_sched_window u_window (
    .clock    (clock),
    .clear    (clear),
    .load     (accept),
    .shift    (step),
    .block_in (block_in),
    .w0       (message_schedule_value)
  );

`ifdef SHA256_SCHED_ROUND_IDX_EN
  logic [5:0] round_index_q, round_index_d;

  // Tracks t on every advance except the wrap after W63, so it holds 63 in IDLE
  always_comb begin
    round_index_d = round_index_q;
    if (accept) begin
      round_index_d = '0;
    end else if (step && (t_q != LAST_T)) begin
      round_index_d = t_q + 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      round_index_q <= '0;
    end else begin
      round_index_q <= round_index_d;
    end
  end

  assign round_index = round_index_q;
`endif

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Self-checking bench for sha256_message_schedule: directed/random block table
// against a behavioural SHA-256 schedule model, plus back-to-back and clear sequences.
module tb_sha256_message_schedule;

  typedef logic [31:0] sched_t [64];

  typedef struct {
    logic [511:0] blk;
    int           hold_t;
    int           hold_len;
    logic [31:0]  exp_w16;
    logic [31:0]  exp_w17;
  } vec_t;

  logic         clock = 1'b0;
  logic         clear;
  logic [511:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic         hold;
  logic [31:0]  value;
  logic         round_valid;
  logic         first_round;
  logic         last_round;
  logic         busy;
`ifdef SHA256_SCHED_ROUND_IDX_EN
  logic [5:0]   round_index;
`endif

  int n_vec = 0;
  int n_err = 0;

  sha256_message_schedule dut (
    .clock                  (clock),
    .clear                  (clear),
    .block_in               (block_in),
    .block_valid            (block_valid),
    .block_ready            (block_ready),
    .hold                   (hold),
    .message_schedule_value (value),
    .round_valid            (round_valid),
    .first_round            (first_round),
    .last_round             (last_round),
    .busy                   (busy)
`ifdef SHA256_SCHED_ROUND_IDX_EN
    ,
    .round_index            (round_index)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 expansion over a full 64-entry array
  function automatic void gen_sched(input logic [511:0] blk, output sched_t w);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom();
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_block(input vec_t v);
    sched_t m;
    int idx, hcnt, cyc;
    gen_sched(v.blk, m);
    @(negedge clock);
    block_in = v.blk;
    block_valid = 1'b1;
    #1;
    check("ready_idle", 32'(block_ready), 32'd1);
    @(negedge clock);
    block_valid = 1'b0;
    block_in = '0;
    idx = 0; hcnt = 0; cyc = 0;
    while (idx < 64 && cyc < 300) begin
      hold = (idx == v.hold_t) && (hcnt < v.hold_len);
      #1;
      if (hold) begin
        check("hold_valid", 32'(round_valid), 32'd0);
        check("hold_flags", 32'({first_round, last_round}), 32'd0);
        check("hold_value", value, m[idx]);
        hcnt++;
      end else begin
        check("valid", 32'(round_valid), 32'd1);
        check("busy", 32'(busy), 32'd1);
        check("ready_run", 32'(block_ready), 32'd0);
        check($sformatf("word%0d", idx), value, m[idx]);
        check("first_round", 32'(first_round), 32'(idx == 0));
        check("last_round", 32'(last_round), 32'(idx == 63));
        if (idx == 16) check("w16", value, v.exp_w16);
        if (idx == 17) check("w17", value, v.exp_w17);
`ifdef SHA256_SCHED_ROUND_IDX_EN
        check("round_index", 32'(round_index), 32'(idx));
`endif
        idx++;
      end
      @(negedge clock);
      cyc++;
    end
    hold = 1'b0;
    if (idx < 64) check("block_timeout", 32'(idx), 32'd64);
    #1;
    check("post_valid", 32'(round_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_ready", 32'(block_ready), 32'd1);
  endtask

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

  vec_t   vecs [8];
  sched_t ma, mb;
  logic [31:0] got [128];
  int     stamp [128];
  int     nw, cyc;

  initial begin
    clear = 1'b1; block_in = '0; block_valid = 1'b0; hold = 1'b0;

    // Reset: block_ready low during clear, all outputs zero
    @(negedge clock);
    block_valid = 1'b1;
    hold = 1'b1;
    @(negedge clock);
    #1;
    check("rst_ready", 32'(block_ready), 32'd0);
    check("rst_valid", 32'(round_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_value", value, 32'd0);
    check("rst_flags", 32'({first_round, last_round}), 32'd0);
    block_valid = 1'b0;
    hold = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("rst_ready_after", 32'(block_ready), 32'd1);
    check("rst_busy_after", 32'(busy), 32'd0);

    vecs[0] = '{ABC, -1, 0, 32'h61626380, 32'h000F0000};
    vecs[1] = '{ABC, 20, 3, 32'h61626380, 32'h000F0000};
    vecs[2] = '{rand_block(), 0, 1, 32'h0, 32'h0};
    vecs[3] = '{rand_block(), 63, 2, 32'h0, 32'h0};
    for (int i = 4; i < 8; i++) begin
      vecs[i] = '{rand_block(), int'($urandom_range(1, 62)), int'($urandom_range(1, 4)), 32'h0, 32'h0};
    end
    for (int i = 2; i < 8; i++) begin
      gen_sched(vecs[i].blk, ma);
      vecs[i].exp_w16 = ma[16];
      vecs[i].exp_w17 = ma[17];
    end
    for (int i = 0; i < 8; i++) run_block(vecs[i]);

    // Back-to-back with block_valid held high through block A
    vecs[0].blk = rand_block();
    gen_sched(ABC, ma);
    gen_sched(vecs[0].blk, mb);
    @(negedge clock);
    block_in = ABC;
    block_valid = 1'b1;
    nw = 0; cyc = 0;
    while (nw < 128 && cyc < 400) begin
      #1;
      if (round_valid) begin
        got[nw] = value;
        stamp[nw] = cyc;
        nw++;
        if (nw < 64) check("b2b_ready_run", 32'(block_ready), 32'd0);
        if (nw == 65) block_valid = 1'b0;
      end
      if (nw >= 1) block_in = vecs[0].blk;
      @(negedge clock);
      cyc++;
    end
    block_valid = 1'b0;
    if (nw < 128) check("b2b_timeout", 32'(nw), 32'd128);
    for (int i = 0; i < nw; i++) begin
      check($sformatf("b2b_word%0d", i), got[i], (i < 64) ? ma[i] : mb[i-64]);
    end
    if (nw >= 65) check("b2b_gap", 32'(stamp[64] - stamp[63]), 32'd2);
    #1;
    check("b2b_idle", 32'(busy), 32'd0);

    // Clear mid-block at t = 30, then restart
    @(negedge clock);
    block_in = ABC;
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    nw = 0; cyc = 0;
    while (nw < 30 && cyc < 100) begin
      #1;
      if (round_valid) nw++;
      @(negedge clock);
      cyc++;
    end
    if (nw < 30) check("clr_timeout", 32'(nw), 32'd30);
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(block_ready), 32'd0);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("clr_valid", 32'(round_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_value", value, 32'd0);
    check("clr_ready_after", 32'(block_ready), 32'd1);
    @(negedge clock);
    #1;
    check("clr_no_valid", 32'(round_valid), 32'd0);
    run_block('{ABC, -1, 0, 32'h61626380, 32'h000F0000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
